// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS decode stage.
//   - Opcode constants for the supported instruction set.
//   - Instruction class encoding and the skid-buffer occupancy state type.
//   - Field widths of the decoded bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int CLASS_W  = 2;

  typedef enum logic [CLASS_W-1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_J   = 2'd2,
    CLS_ILL = 2'd3
  } instr_class_e;

  // Occupancy of the output register (OR) / skid register (SR) pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the
// decode stage.
//   master: the environment (drives in_valid/in_instr/in_pc and out_ready)
//   slave : the decode stage (drives in_ready and all out_* signals)
interface decode_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  import mips_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_W-1:0]    in_instr;
  logic [PC_WIDTH-1:0]   in_pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [OPCODE_W-1:0]   out_opcode;
  logic [REG_W-1:0]      out_rs;
  logic [REG_W-1:0]      out_rt;
  logic [REG_W-1:0]      out_rd;
  logic [SHAMT_W-1:0]    out_shamt;
  logic [FUNCT_W-1:0]    out_funct;
  logic [DATA_WIDTH-1:0] out_imm_sext;
  logic [DATA_WIDTH-1:0] out_imm_zext;
  logic [PC_WIDTH-1:0]   out_jump_addr;
  logic [CLASS_W-1:0]    out_class;
  logic                  out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm_sext, out_imm_zext, out_jump_addr,
           out_class, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm_sext, out_imm_zext, out_jump_addr,
           out_class, out_illegal
  );

endinterface

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational MIPS field splitter.
//   instr_i/pc_i          : raw instruction word and its address
//   opcode_o..funct_o     : R/I/J bit fields
//   imm_sext_o/imm_zext_o : instr[15:0] sign/zero extended to DATA_WIDTH
//   jump_addr_o           : {(pc+4)[PC_WIDTH-1:28], instr[25:0], 2'b00}
//   class_o/illegal_o     : instruction class, illegal flag for class 3
module instr_field_decode
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic [INSTR_W-1:0]    instr_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  output logic [OPCODE_W-1:0]   opcode_o,
  output logic [REG_W-1:0]      rs_o,
  output logic [REG_W-1:0]      rt_o,
  output logic [REG_W-1:0]      rd_o,
  output logic [SHAMT_W-1:0]    shamt_o,
  output logic [FUNCT_W-1:0]    funct_o,
  output logic [DATA_WIDTH-1:0] imm_sext_o,
  output logic [DATA_WIDTH-1:0] imm_zext_o,
  output logic [PC_WIDTH-1:0]   jump_addr_o,
  output logic [CLASS_W-1:0]    class_o,
  output logic                  illegal_o
);

  localparam logic [PC_WIDTH-1:0] REGION_MASK = ~PC_WIDTH'(28'hFFF_FFFF);

  logic [PC_WIDTH-1:0] pc_plus4;

  assign opcode_o = instr_i[31:26];
  assign rs_o     = instr_i[25:21];
  assign rt_o     = instr_i[20:16];
  assign rd_o     = instr_i[15:11];
  assign shamt_o  = instr_i[10:6];
  assign funct_o  = instr_i[5:0];

  assign imm_sext_o = DATA_WIDTH'($signed(instr_i[15:0]));
  assign imm_zext_o = DATA_WIDTH'(instr_i[15:0]);

  // pc+4 wraps at PC_WIDTH; only its 256 MB region bits survive the mask.
  assign pc_plus4    = pc_i + PC_WIDTH'(4);
  assign jump_addr_o = (pc_plus4 & REGION_MASK) | PC_WIDTH'({instr_i[25:0], 2'b00});

  always_comb begin
    class_o = CLS_ILL;
    case (instr_i[31:26])
      OP_RTYPE:                              class_o = CLS_R;
      OP_J, OP_JAL:                          class_o = CLS_J;
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI, OP_LW, OP_SW:         class_o = CLS_I;
      default:                               class_o = CLS_ILL;
    endcase
  end

  assign illegal_o = (class_o == CLS_ILL);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered MIPS decode stage with a 2-entry skid buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous discard of held and incoming instructions
//   bus (slave)  : in_valid/in_ready/in_instr/in_pc from fetch,
//                  out_valid/out_ready plus decoded out_* fields to execute
// The output register (OR) drives the outputs; the skid register (SR) catches
// the one bundle accepted while OR is stalled. in_ready is the registered
// "SR empty" flag, so there is no combinational out_ready -> in_ready path.
module decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_W-1:0]      rs;
    logic [REG_W-1:0]      rt;
    logic [REG_W-1:0]      rd;
    logic [SHAMT_W-1:0]    shamt;
    logic [FUNCT_W-1:0]    funct;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_zext;
    logic [PC_WIDTH-1:0]   jump_addr;
    logic [CLASS_W-1:0]    cls;
    logic                  illegal;
  } bundle_t;

  bundle_t    dec_d;
  bundle_t    or_q;
  bundle_t    sr_q;
  occ_state_e state_q;
  logic       out_valid_q;
  logic       in_ready_q;
  logic       accept;
  logic       drain;

  assign dec_d.pc = bus.in_pc;

  instr_field_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_dec (
    .instr_i     (bus.in_instr),
    .pc_i        (bus.in_pc),
    .opcode_o    (dec_d.opcode),
    .rs_o        (dec_d.rs),
    .rt_o        (dec_d.rt),
    .rd_o        (dec_d.rd),
    .shamt_o     (dec_d.shamt),
    .funct_o     (dec_d.funct),
    .imm_sext_o  (dec_d.imm_sext),
    .imm_zext_o  (dec_d.imm_zext),
    .jump_addr_o (dec_d.jump_addr),
    .class_o     (dec_d.cls),
    .illegal_o   (dec_d.illegal)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      or_q        <= '0;
      sr_q        <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      or_q        <= '0;
      sr_q        <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            or_q        <= dec_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            or_q <= dec_d;
          end else if (accept) begin
            // OR is stalled: park the newer bundle behind it.
            sr_q       <= dec_d;
            in_ready_q <= 1'b0;
            state_q    <= ST_TWO;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the older SR bundle can advance.
          if (drain) begin
            or_q       <= sr_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = or_q.pc;
  assign bus.out_opcode    = or_q.opcode;
  assign bus.out_rs        = or_q.rs;
  assign bus.out_rt        = or_q.rt;
  assign bus.out_rd        = or_q.rd;
  assign bus.out_shamt     = or_q.shamt;
  assign bus.out_funct     = or_q.funct;
  assign bus.out_imm_sext  = or_q.imm_sext;
  assign bus.out_imm_zext  = or_q.imm_zext;
  assign bus.out_jump_addr = or_q.jump_addr;
  assign bus.out_class     = or_q.cls;
  assign bus.out_illegal   = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int BW = 163;
  typedef logic [BW-1:0] pk_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  decode_stage_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();

  decode_stage #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [5:0] legal_i_ops [12] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                   6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  function automatic logic [1:0] ref_class(input logic [5:0] op);
    if (op == 6'h00) return 2'd0;
    if (op == 6'h02 || op == 6'h03) return 2'd2;
    foreach (legal_i_ops[k]) if (legal_i_ops[k] == op) return 2'd1;
    return 2'd3;
  endfunction

  function automatic pk_t exp_pack(input logic [31:0] instr, input logic [31:0] pc);
    logic [31:0] sext, zext, jmp, lo16, pc4;
    logic [1:0]  cls;
    lo16 = instr & 32'h0000_FFFF;
    zext = lo16;
    sext = (lo16 >= 32'h8000) ? (lo16 | 32'hFFFF_0000) : lo16;
    pc4  = pc + 32'd4;
    jmp  = (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    cls  = ref_class(instr[31:26]);
    return {pc, instr[31:26], instr[25:21], instr[20:16], instr[15:11],
            instr[10:6], instr[5:0], sext, zext, jmp, cls, (cls == 2'd3)};
  endfunction

  function automatic pk_t dut_pack();
    return {bus.out_pc, bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd,
            bus.out_shamt, bus.out_funct, bus.out_imm_sext, bus.out_imm_zext,
            bus.out_jump_addr, bus.out_class, bus.out_illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    else n_pass++;
    n_total++;
    if (dut_pack() !== '0) $display("FAIL reset_data got=%h exp=0", dut_pack());
    else n_pass++;
    reset_n = 1'b1;
    step();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL idle_after_reset got=%b exp=0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] ins [6] = '{32'h0022_1820, 32'h8FA8_FFFC, 32'h0810_0000,
                             32'h0810_0000, 32'hFC00_0000, 32'h0BFF_FFFF};
    logic [31:0] pcs [6] = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0000,
                             32'hF000_0000, 32'h0040_0010, 32'hFFFF_FFFC};
    pk_t e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ins[i], pcs[i]);
      step();
      drive(1'b0, 32'h0, 32'h0);
      e = exp_pack(ins[i], pcs[i]);
      n_total++;
      if (bus.out_valid !== 1'b1) $display("FAIL dir%0d_valid got=%b exp=1", i, bus.out_valid);
      else n_pass++;
      n_total++;
      if (dut_pack() !== e) $display("FAIL dir%0d_bundle got=%h exp=%h", i, dut_pack(), e);
      else n_pass++;
      case (i)
        0: begin
          n_total++;
          if ({bus.out_rs, bus.out_rt, bus.out_rd, bus.out_funct, bus.out_class} !== {5'd1, 5'd2, 5'd3, 6'h20, 2'd0})
            $display("FAIL add_fields got=%h", {bus.out_rs, bus.out_rt, bus.out_rd, bus.out_funct, bus.out_class});
          else n_pass++;
        end
        1: begin
          n_total++;
          if ({bus.out_imm_sext, bus.out_imm_zext, bus.out_class} !== {32'hFFFF_FFFC, 32'h0000_FFFC, 2'd1})
            $display("FAIL lw_imm got=%h/%h exp=fffffffc/0000fffc", bus.out_imm_sext, bus.out_imm_zext);
          else n_pass++;
        end
        2: begin
          n_total++;
          if (bus.out_jump_addr !== 32'h0040_0000) $display("FAIL j_addr got=%h exp=00400000", bus.out_jump_addr);
          else n_pass++;
        end
        3: begin
          n_total++;
          if (bus.out_jump_addr !== 32'hF040_0000) $display("FAIL j_addr_hi got=%h exp=f0400000", bus.out_jump_addr);
          else n_pass++;
        end
        4: begin
          n_total++;
          if ({bus.out_class, bus.out_illegal} !== {2'd3, 1'b1}) $display("FAIL illegal got=%0d/%b exp=3/1", bus.out_class, bus.out_illegal);
          else n_pass++;
        end
        5: begin
          n_total++;
          if (bus.out_jump_addr !== 32'h0FFF_FFFC) $display("FAIL j_wrap got=%h exp=0ffffffc", bus.out_jump_addr);
          else n_pass++;
        end
        default: ;
      endcase
    end
    step();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL dir_drain got=%b exp=0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    pk_t exp_s [3];
    pk_t got_s [$];
    logic [31:0] ins [3] = '{32'h0022_1820, 32'h8FA8_FFFC, 32'h3C01_1234};
    logic [31:0] pcs [3] = '{32'h100, 32'h104, 32'h108};
    logic acc;
    int cyc;
    for (int i = 0; i < 3; i++) exp_s[i] = exp_pack(ins[i], pcs[i]);
    bus.out_ready = 1'b0;
    drive(1'b1, ins[0], pcs[0]);
    step();
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b11 || dut_pack() !== exp_s[0])
      $display("FAIL bp_A_loaded got v/r=%b%b exp=11", bus.out_valid, bus.in_ready);
    else n_pass++;
    drive(1'b1, ins[1], pcs[1]);
    step();
    n_total++;
    if (bus.in_ready !== 1'b0 || dut_pack() !== exp_s[0])
      $display("FAIL bp_two_full got in_ready=%b exp=0", bus.in_ready);
    else n_pass++;
    drive(1'b1, ins[2], pcs[2]);
    step();
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10 || dut_pack() !== exp_s[0])
      $display("FAIL bp_hold got v/r=%b%b exp=10", bus.out_valid, bus.in_ready);
    else n_pass++;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (got_s.size() < 3 && cyc < 12) begin
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid) got_s.push_back(dut_pack());
      step();
      if (acc) bus.in_valid = 1'b0;
      cyc++;
    end
    n_total++;
    if (got_s.size() != 3) $display("FAIL bp_count got=%0d exp=3", got_s.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < got_s.size(); i++) begin
      n_total++;
      if (got_s[i] !== exp_s[i]) $display("FAIL bp_order%0d got=%h exp=%h", i, got_s[i], exp_s[i]);
      else n_pass++;
    end
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    pk_t q [$];
    logic rdy_m;
    logic [31:0] instr;
    flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    flush = 1'b0;
    for (int c = 0; c < 500; c++) begin
      n_total++;
      if (bus.out_valid !== (q.size() > 0)) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, q.size() > 0);
      else n_pass++;
      n_total++;
      if (bus.in_ready !== (q.size() < 2)) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.in_ready, q.size() < 2);
      else n_pass++;
      if (q.size() > 0) begin
        n_total++;
        if (dut_pack() !== q[0]) $display("FAIL rnd_bundle c=%0d got=%h exp=%h", c, dut_pack(), q[0]);
        else n_pass++;
      end
      instr = $urandom;
      if ($urandom_range(0, 1) == 0) instr[31:26] = legal_i_ops[$urandom_range(0, 11)];
      else if ($urandom_range(0, 3) == 0) instr[31:26] = 6'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, instr, $urandom & 32'hFFFF_FFFC);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rdy_m = (q.size() < 2);
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy_m) q.push_back(exp_pack(bus.in_instr, bus.in_pc));
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0022_1820, 32'h200);
    step();
    drive(1'b1, 32'h8FA8_FFFC, 32'h204);
    step();
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) $display("FAIL fl_two got v/r=%b%b exp=10", bus.out_valid, bus.in_ready);
    else n_pass++;
    flush = 1'b1;
    drive(1'b1, 32'h0810_0000, 32'h208);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL fl_clear got v/r=%b%b exp=01", bus.out_valid, bus.in_ready);
    else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (bus.out_valid !== 1'b0) $display("FAIL fl_no_emit%0d got=%b exp=0", i, bus.out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h2408_0005, 32'h300);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL ar_loaded got=%b exp=1", bus.out_valid);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL ar_immediate got v/r=%b%b exp=01", bus.out_valid, bus.in_ready);
    else n_pass++;
    n_total++;
    if (dut_pack() !== '0) $display("FAIL ar_data got=%h exp=0", dut_pack());
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL ar_after got=%b exp=0", bus.out_valid);
    else n_pass++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back_stall();
    test_random();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
